// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// with one-word lines, a shared tri-state memory bus and saturating hit/miss stats.
module data_cache_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int LINES     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_done,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WORD_SIZE - IDX_W;

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, RD_CAPT, WR_ISSUE, WR_COMMIT, DONE
    } state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]     valid;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [WORD_SIZE-1:0] data_mem [LINES];
    logic [WORD_SIZE-1:0] wdata_q;

    // Lookup on the live request (IDLE decision) and on the captured address (fill / store update)
    logic [IDX_W-1:0] req_idx, cap_idx;
    logic [TAG_W-1:0] req_tag, cap_tag;
    logic             req_hit, cap_hit;

    assign req_idx = cpu_addr[IDX_W-1:0];
    assign req_tag = cpu_addr[WORD_SIZE-1:IDX_W];
    assign cap_idx = d_address[IDX_W-1:0];
    assign cap_tag = d_address[WORD_SIZE-1:IDX_W];
    assign req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign cap_hit = valid[cap_idx] && (tag_mem[cap_idx] == cap_tag);

    assign d_readM  = (state == RD_ISSUE);
    assign d_writeM = (state == WR_ISSUE);
    assign cpu_done = (state == DONE);
    assign d_data   = (state == WR_ISSUE) ? wdata_q : {WORD_SIZE{1'bz}};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we)       state_nxt = WR_ISSUE;
                    else if (req_hit) state_nxt = DONE;
                    else              state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE:  state_nxt = RD_WAIT;
            RD_WAIT:   state_nxt = RD_CAPT;
            RD_CAPT:   state_nxt = DONE;
            WR_ISSUE:  state_nxt = WR_COMMIT;
            WR_COMMIT: state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            valid      <= '0;
            d_address  <= '0;
            wdata_q    <= '0;
            cpu_rdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu_req) begin
                d_address <= cpu_addr;
                wdata_q   <= cpu_wdata;
                if (req_hit) begin
                    if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                    if (!cpu_we) cpu_rdata <= data_mem[req_idx];
                end else begin
                    if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                end
            end
            if (state == RD_CAPT) begin
                valid[cap_idx] <= 1'b1;
                cpu_rdata      <= d_data;
            end
        end
    end

    // Line payload needs no reset: a cleared valid bit hides it
    always_ff @(posedge clk) begin
        if (state == RD_CAPT) begin
            tag_mem[cap_idx]  <= cap_tag;
            data_mem[cap_idx] <= d_data;
        end else if (state == WR_ISSUE && cap_hit) begin
            data_mem[cap_idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: driver pushes expected responses,
// negedge monitor pops and compares on every cpu_done.
module tb_data_cache_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata, d_address, hit_count, miss_count;
    logic        cpu_done, d_readM, d_writeM;
    wire  [15:0] d_data;

    data_cache_ctrl #(.WORD_SIZE(16), .LINES(4)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .d_readM(d_readM), .d_writeM(d_writeM),
        .d_address(d_address), .d_data(d_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // Memory model: every word initially holds its own address
    logic [15:0] mem [0:255];
    logic        mem_init = 1'b0;
    logic        mem_drive = 1'b0;
    logic [15:0] mem_val = '0;
    logic        probe_drive = 1'b0;
    logic [15:0] probe_val = '0;

    assign d_data = mem_drive ? mem_val : (probe_drive ? probe_val : 16'hzzzz);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_drive <= 1'b0;
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
                mem_init <= 1'b1;
            end
        end else begin
            if (d_readM) begin
                mem_drive <= 1'b1;
                mem_val   <= mem[d_address[7:0]];
            end else if (cpu_done) begin
                mem_drive <= 1'b0;
            end
            if (d_writeM) mem[d_address[7:0]] <= d_data;
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr, wdata, rdata;
        int          lat, n_rd, n_wr;
        logic [15:0] hits, misses;
    } exp_t;
    exp_t q[$];

    // lat = cycles from the cycle in which req is sampled up to the DONE cycle
    int cyc = 0, n_rd = 0, n_wr = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            cyc = 0; n_rd = 0; n_wr = 0;
        end else begin
            exp_t e;
            if (cpu_req) cyc++;
            if (d_readM || d_writeM) check("strobe_excl", {31'b0, d_readM & d_writeM}, 32'd0);
            if (d_readM) begin
                n_rd++;
                if (q.size() != 0) check("rd_addr", {16'b0, d_address}, {16'b0, q[0].addr});
            end
            if (d_writeM) begin
                n_wr++;
                if (q.size() != 0) begin
                    check("wr_addr", {16'b0, d_address}, {16'b0, q[0].addr});
                    check("wr_data", {16'b0, d_data}, {16'b0, q[0].wdata});
                end
            end
            if (cpu_done) begin
                if (q.size() == 0) begin
                    check("done_unexpected", {31'b0, cpu_done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    if (!e.we) check("rdata", {16'b0, cpu_rdata}, {16'b0, e.rdata});
                    check("latency", cyc - 1, e.lat);
                    check("n_readM", n_rd, e.n_rd);
                    check("n_writeM", n_wr, e.n_wr);
                    check("hit_count", {16'b0, hit_count}, {16'b0, e.hits});
                    check("miss_count", {16'b0, miss_count}, {16'b0, e.misses});
                end
                cyc = 0; n_rd = 0; n_wr = 0;
            end
        end
    end

    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int lat, input int nr, input int nw,
                          input logic [15:0] hits, input logic [15:0] misses);
        exp_t e;
        bit   got = 0;
        e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        e.lat = lat; e.n_rd = nr; e.n_wr = nw; e.hits = hits; e.misses = misses;
        q.push_back(e);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_done) begin got = 1; break; end
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            q.delete();
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_readM"}, {31'b0, d_readM}, 32'd0);
        check({tag, "_writeM"}, {31'b0, d_writeM}, 32'd0);
        check({tag, "_done"}, {31'b0, cpu_done}, 32'd0);
        check({tag, "_addr"}, {16'b0, d_address}, 32'd0);
        check({tag, "_rdata"}, {16'b0, cpu_rdata}, 32'd0);
        check({tag, "_hits"}, {16'b0, hit_count}, 32'd0);
        check({tag, "_misses"}, {16'b0, miss_count}, 32'd0);
    endtask

    // DUT must not drive the bus: a bench-driven pattern reads back intact
    task automatic bus_probe(input string tag);
        probe_drive = 1'b1;
        probe_val = 16'h0000; #1;
        check({tag, "_bus_lo"}, {16'b0, d_data}, 32'h0000);
        probe_val = 16'hFFFF; #1;
        check({tag, "_bus_hi"}, {16'b0, d_data}, 32'hFFFF);
        probe_drive = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        bus_probe("por");
        reset_n = 1'b1;

        //     we    addr      wdata     rdata     lat nr nw hits misses
        access(1'b0, 16'h0001, 16'h0000, 16'h0001, 4, 1, 0, 16'd0, 16'd1);
        access(1'b0, 16'h0001, 16'h0000, 16'h0001, 1, 0, 0, 16'd1, 16'd1);
        access(1'b1, 16'h0001, 16'hABCD, 16'h0000, 3, 0, 1, 16'd2, 16'd1);
        access(1'b0, 16'h0001, 16'h0000, 16'hABCD, 1, 0, 0, 16'd3, 16'd1);
        access(1'b0, 16'h0005, 16'h0000, 16'h0005, 4, 1, 0, 16'd3, 16'd2);
        access(1'b0, 16'h0001, 16'h0000, 16'hABCD, 4, 1, 0, 16'd3, 16'd3);
        access(1'b1, 16'h0010, 16'h1234, 16'h0000, 3, 0, 1, 16'd3, 16'd4);
        access(1'b0, 16'h0010, 16'h0000, 16'h1234, 4, 1, 0, 16'd3, 16'd5);
        access(1'b0, 16'h0001, 16'h0000, 16'hABCD, 1, 0, 0, 16'd4, 16'd5);
        access(1'b1, 16'h0009, 16'h9999, 16'h0000, 3, 0, 1, 16'd4, 16'd6);
        access(1'b0, 16'h0001, 16'h0000, 16'hABCD, 1, 0, 0, 16'd5, 16'd6);
        access(1'b0, 16'h0009, 16'h0000, 16'h9999, 4, 1, 0, 16'd5, 16'd7);
        access(1'b1, 16'h0009, 16'h7777, 16'h0000, 3, 0, 1, 16'd6, 16'd7);
        access(1'b0, 16'h0009, 16'h0000, 16'h7777, 1, 0, 0, 16'd7, 16'd7);
        @(negedge clk);
        bus_probe("idle");

        // Abort a load miss while it waits on memory
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_reset_outputs("abort");
        bus_probe("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", {31'b0, cpu_done}, 32'd0);

        access(1'b0, 16'h0009, 16'h0000, 16'h7777, 4, 1, 0, 16'd0, 16'd1);
        access(1'b0, 16'h0002, 16'h0000, 16'h0002, 4, 1, 0, 16'd0, 16'd2);
        access(1'b0, 16'h0002, 16'h0000, 16'h0002, 1, 0, 0, 16'd1, 16'd2);

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
